hazard_scoreboard: RTL

- Parametrised successor to the single-cycle load-use hazard detector in the decode stage.
- Keeps the EX-stage load-use stall and load-to-store forwarding.
- Adds a per-register pending-write scoreboard for variable-latency ops (memory loads, mul/div) that write back out of order. These ops get RAW/WAW stalls, an outstanding-op limit, a stall-cycle performance counter and a sticky protocol-error flag.

---
 rtl/hazard_scoreboard.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: EX load-use stall with load-to-store forwarding, plus a
// per-register pending-write scoreboard for out-of-order long-latency writebacks.
module hazard_scoreboard #(
  parameter int REG_ADDR_W      = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32,
  parameter int LOAD_STORE_FWD  = 1,
  parameter int WB_BYPASS       = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 id_valid_i,
  input  logic [REG_ADDR_W-1:0]                id_rs1_i,
  input  logic [REG_ADDR_W-1:0]                id_rs2_i,
  input  logic                                 id_uses_rs1_i,
  input  logic                                 id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0]                id_rd_i,
  input  logic                                 id_writes_rd_i,
  input  logic                                 id_long_lat_i,
  input  logic                                 id_is_store_i,
  input  logic                                 ex_is_load_i,
  input  logic [REG_ADDR_W-1:0]                ex_rd_i,
  input  logic                                 wb_valid_i,
  input  logic [REG_ADDR_W-1:0]                wb_rd_i,
  output logic                                 stall_o,
  output logic                                 load_store_forward_sel_o,
  output logic                                 busy_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] pending_count_o,
  output logic [CNT_W-1:0]                     stall_cycles_o,
  output logic                                 protocol_err_o
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam int PCW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PCW-1:0] MAX_CNT = PCW'(MAX_OUTSTANDING);

  logic [NREG-1:0]  r_pending;
  logic [PCW-1:0]   r_count;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err;

  logic            w_id_active;
  logic            w_byp_rs1;
  logic            w_byp_rs2;
  logic            w_byp_rd;
  logic            w_hz_rs1;
  logic            w_hz_rs2;
  logic            w_hz_rd;
  logic            w_raw;
  logic            w_waw;
  logic            w_full;
  logic            w_lu1;
  logic            w_lu2;
  logic            w_fwd;
  logic            w_stall;
  logic            w_issue;
  logic            w_wb_hit;
  logic            w_wb_err;
  logic [NREG-1:0] w_pending_nxt;

  // Gating with rst_ni keeps the combinational outputs at 0 while reset is held.
  assign w_id_active = id_valid_i && rst_ni;

  // A same-cycle writeback of a source register resolves it (write-through file).
  assign w_byp_rs1 = (WB_BYPASS != 0) && wb_valid_i && (wb_rd_i == id_rs1_i);
  assign w_byp_rs2 = (WB_BYPASS != 0) && wb_valid_i && (wb_rd_i == id_rs2_i);
  assign w_byp_rd  = (WB_BYPASS != 0) && wb_valid_i && (wb_rd_i == id_rd_i);

  assign w_hz_rs1 = (id_rs1_i != '0) && r_pending[id_rs1_i] && !w_byp_rs1;
  assign w_hz_rs2 = (id_rs2_i != '0) && r_pending[id_rs2_i] && !w_byp_rs2;
  assign w_hz_rd  = (id_rd_i  != '0) && r_pending[id_rd_i]  && !w_byp_rd;

  assign w_raw  = w_id_active && ((id_uses_rs1_i && w_hz_rs1) || (id_uses_rs2_i && w_hz_rs2));
  assign w_waw  = w_id_active && id_writes_rd_i && w_hz_rd;
  assign w_full = w_id_active && id_long_lat_i && id_writes_rd_i && (id_rd_i != '0) &&
                  (r_count == MAX_CNT);

  assign w_lu1 = w_id_active && ex_is_load_i && (ex_rd_i != '0) && id_uses_rs1_i &&
                 (id_rs1_i == ex_rd_i);
  assign w_lu2 = w_id_active && ex_is_load_i && (ex_rd_i != '0) && id_uses_rs2_i &&
                 (id_rs2_i == ex_rd_i);

  // Only a store-data match can be forwarded; an address match still stalls.
  assign w_fwd = (LOAD_STORE_FWD != 0) && id_is_store_i && w_lu2 && !w_lu1;

  assign w_stall = w_raw || w_waw || w_full || w_lu1 || (w_lu2 && !w_fwd);

  assign w_issue = w_id_active && !w_stall && id_long_lat_i && id_writes_rd_i &&
                   (id_rd_i != '0);

  // wb_valid_i is a one-cycle completion strobe with no back-pressure: the unit always
  // consumes it; a writeback to a register with no pending write flags an error.
  assign w_wb_hit = wb_valid_i && (wb_rd_i != '0) && r_pending[wb_rd_i];
  assign w_wb_err = wb_valid_i && (wb_rd_i != '0) && !r_pending[wb_rd_i];

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_hit) w_pending_nxt[wb_rd_i] = 1'b0;
    // Set after clear so a same-register collision leaves the bit pending.
    if (w_issue) w_pending_nxt[id_rd_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending   <= '0;
      r_count     <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_issue && !w_wb_hit) begin
        r_count <= r_count + PCW'(1);
      end else if (w_wb_hit && !w_issue) begin
        r_count <= r_count - PCW'(1);
      end
      if (w_wb_err) r_err <= 1'b1;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_o                  = w_stall;
  assign load_store_forward_sel_o = w_fwd && !w_stall;
  assign busy_o                   = |r_pending;
  assign pending_count_o          = r_count;
  assign stall_cycles_o           = r_stall_cnt;
  assign protocol_err_o           = r_err;

endmodule
